mem_arbiter_ctrl: RTL and testbench

Parametrised successor to the single-port memory controller. It arbitrates `NCH` CPU-side channels (e.g. instruction fetch and load/store) onto the one byte-wide RAM port. Each `C_DATA_L`-bit word access, of 1..`BYTES` bytes, is split into a sequence of `M_DATA_L`-bit RAM transactions. It sits between `riscv_cpu` and `ram`, and replaces the fixed 4-byte, single-channel controller.

---
 rtl/mem_arbiter_ctrl_pkg.sv | 20 ++
 rtl/mem_arbiter_ctrl_rr_arbiter.sv | 32 +++
 rtl/mem_arbiter_ctrl.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_ctrl_pkg.sv
// Shared definitions for the multi-channel byte-serialising memory controller:
// FSM state encodings and the width-derivation helpers used by every file.
package mem_arbiter_ctrl_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] ACK  = 2'd3;

    // Number of RAM beats that make up one CPU word.
    function automatic int calc_bytes(input int c_data_l, input int m_data_l);
        return c_data_l / m_data_l;
    endfunction

    // Index width for n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_arbiter_ctrl_rr_arbiter.sv
// Round-robin request picker: first requesting channel at or after ptr,
// searching upward and wrapping modulo NCH.
module rr_arbiter
    import mem_arbiter_ctrl_pkg::*;
#(
    parameter  int NCH  = 2,
    localparam int CH_W = idx_width(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] gnt_idx,
    output logic            gnt_vld
);

    always_comb begin
        int              j;
        logic [CH_W-1:0] cand;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        j       = 0;
        cand    = '0;
        for (int i = 0; i < NCH; i++) begin
            j    = (int'(ptr) + i) % NCH;
            cand = CH_W'(j);
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Arbitrates NCH CPU channels onto one narrow RAM port, splitting each word
// access of 1..BYTES beats into a handshaked sequence of RAM transactions.
module mem_arbiter_ctrl
    import mem_arbiter_ctrl_pkg::*;
#(
    parameter  int MADDR_L  = 32,
    parameter  int M_DATA_L = 8,
    parameter  int C_DATA_L = 32,
    parameter  int NCH      = 2,
    localparam int BYTES    = calc_bytes(C_DATA_L, M_DATA_L),
    localparam int LEN_W    = idx_width(BYTES),
    localparam int CH_W     = idx_width(NCH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH*MADDR_L-1:0]  c_raddr,
    input  logic [NCH*MADDR_L-1:0]  c_waddr,
    input  logic [NCH*C_DATA_L-1:0] c_din,
    input  logic [NCH*LEN_W-1:0]    c_len,
    input  logic [NCH-1:0]          c_re,
    input  logic [NCH-1:0]          c_we,
    output logic [C_DATA_L-1:0]     c_dout,
    output logic [NCH-1:0]          c_rack,
    output logic [NCH-1:0]          c_wack,
    output logic [MADDR_L-1:0]      m_raddr,
    output logic [MADDR_L-1:0]      m_waddr,
    output logic [M_DATA_L-1:0]     m_dout,
    input  logic [M_DATA_L-1:0]     m_din,
    output logic                    m_re,
    output logic                    m_we,
    input  logic                    m_rack,
    input  logic                    m_wack
);

    logic [1:0]          state_q, state_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                wr_q, wr_d;
    logic                req_q, req_d;
    logic                last_q, last_d;

    logic [MADDR_L-1:0]  addr_q, addr_d;
    logic [C_DATA_L-1:0] data_q, data_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    k_q, k_d;
    logic [C_DATA_L-1:0] asm_q, asm_d;

    logic [CH_W-1:0]     gnt_idx;
    logic                gnt_vld;
    logic [MADDR_L-1:0]  byte_addr;
    logic                beat_ack;

    rr_arbiter #(.NCH(NCH)) u_rr_arbiter (
        .req     (c_re | c_we),
        .ptr     (rr_ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign byte_addr = addr_q + MADDR_L'(k_q);
    assign beat_ack  = (state_q == RD) ? m_rack : m_wack;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        ch_d     = ch_q;
        wr_d     = wr_q;
        req_d    = req_q;
        last_d   = last_q;
        addr_d   = addr_q;
        data_d   = data_q;
        len_d    = len_q;
        k_d      = k_q;
        asm_d    = asm_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    // A channel asking for both is served as a write first.
                    ch_d     = gnt_idx;
                    rr_ptr_d = (int'(gnt_idx) + 1 == NCH) ? '0 : gnt_idx + 1'b1;
                    wr_d     = c_we[gnt_idx];
                    addr_d   = wr_d ? c_waddr[int'(gnt_idx)*MADDR_L +: MADDR_L]
                                    : c_raddr[int'(gnt_idx)*MADDR_L +: MADDR_L];
                    data_d   = c_din[int'(gnt_idx)*C_DATA_L +: C_DATA_L];
                    len_d    = c_len[int'(gnt_idx)*LEN_W +: LEN_W];
                    k_d      = '0;
                    asm_d    = '0;
                    req_d    = 1'b1;
                    last_d   = 1'b0;
                    state_d  = wr_d ? WR : RD;
                end
            end
            RD, WR: begin
                if (req_q) begin
                    if (beat_ack) begin
                        req_d  = 1'b0;
                        last_d = (k_q == len_q);
                        if (state_q == RD) begin
                            asm_d[int'(k_q)*M_DATA_L +: M_DATA_L] = m_din;
                        end
                    end
                end else if (last_q) begin
                    state_d = ACK;
                end else begin
                    // Request-low gap cycle: advance to the next beat.
                    k_d   = k_q + 1'b1;
                    req_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            ch_q     <= '0;
            wr_q     <= 1'b0;
            req_q    <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            ch_q     <= ch_d;
            wr_q     <= wr_d;
            req_q    <= req_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        len_q  <= len_d;
        k_q    <= k_d;
        asm_q  <= asm_d;
    end

    // Outputs are gated by state so reset forces them all to zero at once.
    always_comb begin
        m_re    = (state_q == RD) && req_q;
        m_we    = (state_q == WR) && req_q;
        m_raddr = (state_q == RD) ? byte_addr : '0;
        m_waddr = (state_q == WR) ? byte_addr : '0;
        m_dout  = (state_q == WR) ? data_q[int'(k_q)*M_DATA_L +: M_DATA_L] : '0;
        c_dout  = (state_q == ACK && !wr_q) ? asm_q : '0;
        c_rack  = '0;
        c_wack  = '0;
        if (state_q == ACK) begin
            if (wr_q) c_wack[ch_q] = 1'b1;
            else      c_rack[ch_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed and randomized checks of mem_arbiter_ctrl against a byte-addressed
// memory model with programmable acknowledge latency.
module tb_mem_arbiter_ctrl;

    localparam int MADDR_L  = 32;
    localparam int M_DATA_L = 8;
    localparam int C_DATA_L = 32;
    localparam int NCH      = 2;
    localparam int BYTES    = 4;
    localparam int LEN_W    = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NCH*MADDR_L-1:0]  c_raddr = '0;
    logic [NCH*MADDR_L-1:0]  c_waddr = '0;
    logic [NCH*C_DATA_L-1:0] c_din   = '0;
    logic [NCH*LEN_W-1:0]    c_len   = '0;
    logic [NCH-1:0]          c_re    = '0;
    logic [NCH-1:0]          c_we    = '0;
    logic [C_DATA_L-1:0]     c_dout;
    logic [NCH-1:0]          c_rack, c_wack;
    logic [MADDR_L-1:0]      m_raddr, m_waddr;
    logic [M_DATA_L-1:0]     m_dout;
    logic [M_DATA_L-1:0]     m_din  = '0;
    logic                    m_re, m_we;
    logic                    m_rack = 1'b0;
    logic                    m_wack = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_ctrl #(
        .MADDR_L(MADDR_L), .M_DATA_L(M_DATA_L), .C_DATA_L(C_DATA_L), .NCH(NCH)
    ) dut (
        .clk(clk), .rst(rst),
        .c_raddr(c_raddr), .c_waddr(c_waddr), .c_din(c_din), .c_len(c_len),
        .c_re(c_re), .c_we(c_we), .c_dout(c_dout), .c_rack(c_rack), .c_wack(c_wack),
        .m_raddr(m_raddr), .m_waddr(m_waddr), .m_dout(m_dout), .m_din(m_din),
        .m_re(m_re), .m_we(m_we), .m_rack(m_rack), .m_wack(m_wack)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 1;
    bit spur_en  = 1'b0;
    int acnt     = 0;
    int both_viol = 0;
    int rack_cnt[NCH];
    int wack_cnt[NCH];
    int exp_rack[NCH];
    int exp_wack[NCH];

    logic [7:0] ram     [bit [31:0]];
    logic [7:0] exp_mem [bit [31:0]];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] exp_rd(input logic [31:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : init_byte(a);
    endfunction

    // Expected read word: bytes 0..len from the reference memory, zeros above.
    function automatic logic [31:0] exp_word(input logic [31:0] a, input int len);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i <= len; i++) w[i*8 +: 8] = exp_rd(a + 32'(i));
        return w;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: acknowledges in the lat-th cycle a request is held high.
    always @(negedge clk) begin
        m_rack = 1'b0;
        m_wack = 1'b0;
        if (!rst || !(m_re || m_we)) acnt = 0;
        if (rst && m_re && m_we) both_viol++;
        if (rst && m_re) begin
            acnt++;
            if (acnt >= lat) begin
                m_rack = 1'b1;
                m_din  = ram_rd(m_raddr);
                acnt   = 0;
            end else if (spur_en) begin
                m_wack = 1'($urandom);
                m_din  = 8'($urandom);
            end
        end else if (rst && m_we) begin
            acnt++;
            if (acnt >= lat) begin
                m_wack = 1'b1;
                ram[m_waddr] = m_dout;
                acnt   = 0;
            end else if (spur_en) begin
                m_rack = 1'($urandom);
            end
        end else if (spur_en) begin
            m_rack = 1'($urandom);
            m_wack = 1'($urandom);
            m_din  = 8'($urandom);
        end
        for (int i = 0; i < NCH; i++) begin
            rack_cnt[i] += int'(c_rack[i]);
            wack_cnt[i] += int'(c_wack[i]);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic [31:0] addr, input int len,
                          input logic [31:0] data);
        c_raddr[ch*MADDR_L +: MADDR_L] = addr;
        c_waddr[ch*MADDR_L +: MADDR_L] = addr;
        c_len[ch*LEN_W +: LEN_W]       = LEN_W'(len);
        c_din[ch*C_DATA_L +: C_DATA_L] = data;
    endtask

    // One complete access on one channel, checked for latency, data and RAM image.
    task automatic access(input int ch, input bit we, input logic [31:0] addr,
                          input int len, input logic [31:0] data);
        int          t0;
        bit          done;
        logic [31:0] expw;
        @(negedge clk);
        expw = exp_word(addr, len);
        set_ch(ch, addr, len, data);
        if (we) c_we[ch] = 1'b1;
        else    c_re[ch] = 1'b1;
        t0   = cyc;
        done = 1'b0;
        for (int t = 0; t < 1000 && !done; t++) begin
            @(negedge clk);
            done = we ? c_wack[ch] : c_rack[ch];
        end
        c_we[ch] = 1'b0;
        c_re[ch] = 1'b0;
        check(we ? "wr_done" : "rd_done", 64'(done), 64'd1);
        if (done) begin
            check("latency", 64'(cyc - t0), 64'((len + 1) * (lat + 1) + 1));
            if (we) begin
                exp_wack[ch]++;
                for (int i = 0; i <= len; i++) exp_mem[addr + 32'(i)] = data[i*8 +: 8];
                for (int i = -1; i <= BYTES; i++)
                    check("ram_byte", 64'(ram_rd(addr + 32'(i))), 64'(exp_rd(addr + 32'(i))));
            end else begin
                exp_rack[ch]++;
                check("rd_data", 64'(c_dout), 64'(expw));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          got[$];
        int          t;
        bit          done;
        logic [31:0] rr_exp[NCH];
        int          r_ch, r_len;
        bit          r_we;
        logic [31:0] r_addr;

        for (int i = 0; i < NCH; i++) begin
            rack_cnt[i] = 0; wack_cnt[i] = 0; exp_rack[i] = 0; exp_wack[i] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            ram[32'h100 + 32'(i)]     = 8'(8'h11 * (i + 1));
            exp_mem[32'h100 + 32'(i)] = 8'(8'h11 * (i + 1));
        end

        // Outputs while held in reset.
        repeat (3) @(negedge clk);
        check("rst_m_re", 64'(m_re), 64'd0);
        check("rst_m_we", 64'(m_we), 64'd0);
        check("rst_c_rack", 64'(c_rack), 64'd0);
        check("rst_c_wack", 64'(c_wack), 64'd0);
        check("rst_c_dout", 64'(c_dout), 64'd0);
        check("rst_m_raddr", 64'(m_raddr), 64'd0);
        check("rst_m_dout", 64'(m_dout), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Round robin with both channels reading continuously.
        lat = 1;
        set_ch(0, 32'h300, 3, 32'h0);
        set_ch(1, 32'h400, 1, 32'h0);
        rr_exp[0] = exp_word(32'h300, 3);
        rr_exp[1] = exp_word(32'h400, 1);
        c_re = 2'b11;
        t = 0;
        while (got.size() < 4 && t < 500) begin
            @(negedge clk);
            t++;
            for (int ch = 0; ch < NCH; ch++) begin
                if (c_rack[ch]) begin
                    got.push_back(ch);
                    exp_rack[ch]++;
                    check("rr_data", 64'(c_dout), 64'(rr_exp[ch]));
                end
            end
        end
        c_re = '0;
        for (int i = 0; i < 4; i++)
            check("rr_order", 64'((got.size() > i) ? got[i] : 99), 64'(i % 2));

        // Single 4-byte read with two-cycle RAM latency.
        lat = 2;
        access(0, 1'b0, 32'h100, 3, 32'h0);

        // Halfword write on channel 1.
        lat = 1;
        access(1, 1'b1, 32'h200, 1, 32'hDEADBEEF);
        check("hw_byte0", 64'(ram_rd(32'h200)), 64'hEF);
        check("hw_byte1", 64'(ram_rd(32'h201)), 64'hBE);

        // Write and read requested together on one channel.
        @(negedge clk);
        set_ch(0, 32'h500, 3, 32'hCAFEF00D);
        c_re[0] = 1'b1;
        c_we[0] = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = c_wack[0] | c_rack[0];
        end
        check("both_wr_first", 64'(c_wack[0]), 64'd1);
        c_we[0] = 1'b0;
        exp_wack[0]++;
        for (int i = 0; i < 4; i++) exp_mem[32'h500 + 32'(i)] = 8'(32'hCAFEF00D >> (8 * i));
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = c_rack[0];
        end
        c_re[0] = 1'b0;
        check("both_rd_after", 64'(done), 64'd1);
        check("both_rd_data", 64'(c_dout), 64'hCAFEF00D);
        exp_rack[0]++;

        // Address wrap at the top of the address space.
        access(0, 1'b0, 32'hFFFFFFFE, 3, 32'h0);
        lat = 2;
        access(1, 1'b1, 32'hFFFFFFFE, 3, 32'h44332211);
        check("wrap_b0", 64'(ram_rd(32'hFFFFFFFE)), 64'h11);
        check("wrap_b3", 64'(ram_rd(32'h00000001)), 64'h44);

        // Reset asserted while byte 2 of a write is outstanding.
        lat = 3;
        @(negedge clk);
        set_ch(0, 32'h600, 3, 32'h87654321);
        c_we[0] = 1'b1;
        t = 0;
        while (!(m_we && m_waddr == 32'h602) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("rst_reach_b2", 64'(m_we && m_waddr == 32'h602), 64'd1);
        rst = 1'b0;
        #1;
        check("arst_m_we", 64'(m_we), 64'd0);
        check("arst_m_waddr", 64'(m_waddr), 64'd0);
        check("arst_m_dout", 64'(m_dout), 64'd0);
        check("arst_c_wack", 64'(c_wack), 64'd0);
        c_we[0] = 1'b0;
        exp_mem[32'h600] = 8'h21;
        exp_mem[32'h601] = 8'h43;
        @(negedge clk);
        rst = 1'b1;
        for (int i = -1; i <= BYTES; i++)
            check("arst_ram", 64'(ram_rd(32'h600 + 32'(i))), 64'(exp_rd(32'h600 + 32'(i))));
        lat = 1;
        access(0, 1'b0, 32'h600, 3, 32'h0);

        // Randomized traffic with spurious acknowledges.
        for (int n = 0; n < 40; n++) begin
            r_ch    = int'($urandom_range(NCH - 1, 0));
            r_we    = 1'($urandom);
            r_len   = int'($urandom_range(BYTES - 1, 0));
            lat     = int'($urandom_range(3, 1));
            spur_en = 1'($urandom);
            r_addr  = ($urandom_range(4, 0) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(3, 0))
                                                  : 32'h1000 + 32'($urandom_range(63, 0));
            access(r_ch, r_we, r_addr, r_len, $urandom);
        end
        spur_en = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < NCH; i++) begin
            check("rack_pulses", 64'(rack_cnt[i]), 64'(exp_rack[i]));
            check("wack_pulses", 64'(wack_cnt[i]), 64'(exp_wack[i]));
        end
        check("re_we_excl", 64'(both_viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
